// File: rtl/cpu_pkg.sv
// Shared fetch-path types: bus widths, fetch FSM states and the buffered instruction record.
package cpu_pkg;

  localparam int unsigned ADDR_WIDTH = 8;
  localparam int unsigned LINE_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH_OP  = 2'd1,
    FETCH_ARG = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [LINE_WIDTH-1:0] opcode;
    logic [LINE_WIDTH-1:0] operand;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: memory read port, branch redirect and the decode valid/ready handshake.
interface instruction_fetch_if;
  import cpu_pkg::*;

  logic                  fetch_enable;
  logic [ADDR_WIDTH-1:0] mem_read_address;
  logic [LINE_WIDTH-1:0] mem_read_data;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [LINE_WIDTH-1:0] instr_opcode;
  logic [LINE_WIDTH-1:0] instr_operand;
  logic [ADDR_WIDTH-1:0] instr_pc;

  modport master (
    input  fetch_enable,
    output mem_read_address,
    input  mem_read_data,
    input  redirect_valid,
    input  redirect_pc,
    output instr_valid,
    input  instr_ready,
    output instr_opcode,
    output instr_operand,
    output instr_pc
  );

  modport slave (
    output fetch_enable,
    input  mem_read_address,
    output mem_read_data,
    output redirect_valid,
    output redirect_pc,
    input  instr_valid,
    output instr_ready,
    input  instr_opcode,
    input  instr_operand,
    input  instr_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer with flush; head reads as zero while empty.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  fetch_entry_t             data_i,
  output fetch_entry_t             data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(Depth);

  fetch_entry_t    mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == DepthCnt);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // A push into a full buffer is legal when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: reads opcode/operand byte pairs from memory and queues them toward decode.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 8'h00,
  parameter int unsigned           FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  instruction_fetch_if.master fetch_io
);

  fetch_state_t               state_q, state_d;
  logic [ADDR_WIDTH-1:0]      pc_q, pc_d;
  logic [LINE_WIDTH-1:0]      opcode_q, opcode_d;

  fetch_entry_t               push_entry, head_entry;
  logic                       fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_space;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  // A pop coinciding with a redirect is dropped along with the flushed contents.
  assign fifo_pop   = ~fifo_empty & fetch_io.instr_ready & ~fetch_io.redirect_valid;
  assign fifo_space = ~fifo_full | fifo_pop;
  assign push_entry = '{pc: pc_q, opcode: opcode_q, operand: fetch_io.mem_read_data};

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    opcode_d  = opcode_q;
    fifo_push = 1'b0;
    if (fetch_io.redirect_valid) begin
      pc_d     = fetch_io.redirect_pc;
      opcode_d = '0;
      state_d  = fetch_io.fetch_enable ? FETCH_OP : IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fetch_io.fetch_enable) state_d = FETCH_OP;
        end
        FETCH_OP: begin
          if (fetch_io.fetch_enable) begin
            opcode_d = fetch_io.mem_read_data;
            state_d  = FETCH_ARG;
          end else begin
            state_d = IDLE;
          end
        end
        FETCH_ARG: begin
          // Without buffer space the operand read simply repeats next cycle.
          if (fifo_space) begin
            fifo_push = 1'b1;
            pc_d      = pc_q + ADDR_WIDTH'(2);
            state_d   = fetch_io.fetch_enable ? FETCH_OP : IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      opcode_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      opcode_q <= opcode_d;
    end
  end

  assign fetch_io.mem_read_address = (state_q == FETCH_ARG) ? pc_q + ADDR_WIDTH'(1) : pc_q;

  fetch_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk_i    (clk),
    .reset_ni (reset_n),
    .push_i   (fifo_push),
    .pop_i    (fifo_pop),
    .flush_i  (fetch_io.redirect_valid),
    .data_i   (push_entry),
    .data_o   (head_entry),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count)
  );

  assign fetch_io.instr_valid   = ~fifo_empty;
  assign fetch_io.instr_pc      = head_entry.pc;
  assign fetch_io.instr_opcode  = head_entry.opcode;
  assign fetch_io.instr_operand = head_entry.operand;

  a_count_bound: assert property (@(posedge clk) disable iff (!reset_n)
    int'(fifo_count) <= int'(FIFO_DEPTH));

endmodule
